// File: rtl/ovc_credit_req_mask_pkg.sv
// ovc_credit_req_mask_pkg
//   Shared constants and helper functions for the output-VC credit/request
//   mask block: default OVC count, per-VC buffer depth, requester count,
//   and a ceiling-log2 helper used to size index and counter fields.
package ovc_credit_req_mask_pkg;

  localparam int OVC_V_DEFAULT = 4;  // OVCs per output port
  localparam int OVC_B_DEFAULT = 4;  // flit buffer depth per downstream VC
  localparam int OVC_R_DEFAULT = 8;  // requesting IVCs

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int ovc_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int ovc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ovc_credit_counter.sv
// ovc_credit_counter
//   Credit counter, allocated flag and overflow/underflow detection for one
//   output VC.
//   Ports:
//     clk, reset   clock; asynchronous active-high reset
//     dec          a flit was forwarded on this OVC this cycle
//     inc          a credit was returned for this OVC this cycle
//     alloc_set    OVC allocated to a packet this cycle
//     alloc_clr    tail flit forwarded on this OVC this cycle
//     err_event    attempted decrement at 0 or increment at B (this cycle)
//     free         unallocated and all credits home (registered state only)
//     full         no credits left (registered state only)
//     ok           a flit may be sent next: cnt >= 2, or cnt == 1 with no
//                  send in progress this cycle
module ovc_credit_counter
  import ovc_credit_req_mask_pkg::*;
#(
  parameter int B  = OVC_B_DEFAULT,
  parameter int CW = ovc_log2(B + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic dec,
  input  logic inc,
  input  logic alloc_set,
  input  logic alloc_clr,
  output logic err_event,
  output logic free,
  output logic full,
  output logic ok
);

  localparam logic [CW-1:0] CNT_MAX = CW'(B);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          alloc_reg;
  logic          alloc_next;

  // Send and credit in the same cycle cancel, so neither can fault.
  always_comb begin
    cnt_next  = cnt_reg;
    err_event = 1'b0;
    if (dec && !inc) begin
      if (cnt_reg == '0) err_event = 1'b1;
      else               cnt_next  = cnt_reg - CNT_ONE;
    end else if (inc && !dec) begin
      if (cnt_reg == CNT_MAX) err_event = 1'b1;
      else                    cnt_next  = cnt_reg + CNT_ONE;
    end
  end

  // A new allocation wins over a tail closing the previous packet.
  assign alloc_next = alloc_set | (alloc_reg & ~alloc_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= CNT_MAX;
      alloc_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      alloc_reg <= alloc_next;
    end
  end

  assign free = ~alloc_reg & (cnt_reg == CNT_MAX);
  assign full = (cnt_reg == '0);
  // The last credit is only usable if it is not being consumed right now.
  assign ok   = (cnt_reg > CNT_ONE) | ((cnt_reg == CNT_ONE) & ~dec);

endmodule

// File: rtl/ovc_credit_req_mask.sv
// ovc_credit_req_mask
//   Tracks downstream credits and allocation state for each output VC of a
//   router output port and filters switch requests from the IVCs so that
//   only requests that can make progress reach the allocator.
//   Optional feature: define OVC_CREDIT_REG_EN to register credit_in for one
//   cycle before it is counted (a credit then takes effect two cycles after
//   arrival instead of one).
//   Ports:
//     clk, reset                      clock; asynchronous active-high reset
//     req_in[R]                       IVC has a flit waiting
//     req_assigned[R]                 IVC already holds an OVC of this port
//     req_ovc[R*VW]                   OVC index per IVC (valid when assigned)
//     req_out[R]                      filtered request (combinational)
//     flit_sent, flit_sent_ovc        flit forwarded downstream on an OVC
//     flit_sent_tail                  that flit is a tail
//     alloc_valid, alloc_ovc          OVC allocated to a packet
//     credit_in[V]                    per-OVC credit return
//     ovc_free[V]                     unallocated with all credits home
//     ovc_full[V]                     no credits left
//     err_sticky                      credit overflow/underflow seen
module ovc_credit_req_mask
  import ovc_credit_req_mask_pkg::*;
#(
  parameter  int V  = OVC_V_DEFAULT,
  parameter  int B  = OVC_B_DEFAULT,
  parameter  int R  = OVC_R_DEFAULT,
  localparam int VW = ovc_max(1, ovc_log2(V)),
  localparam int CW = ovc_log2(B + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [R-1:0]  req_in,
  input  logic [R-1:0]  req_assigned,
  input  logic [R*VW-1:0] req_ovc,
  output logic [R-1:0]  req_out,
  input  logic          flit_sent,
  input  logic [VW-1:0] flit_sent_ovc,
  input  logic          flit_sent_tail,
  input  logic          alloc_valid,
  input  logic [VW-1:0] alloc_ovc,
  input  logic [V-1:0]  credit_in,
  output logic [V-1:0]  ovc_free,
  output logic [V-1:0]  ovc_full,
  output logic          err_sticky
);

  // Index space of an OVC field; entries beyond V read as "not ok".
  localparam int VP = 1 << VW;

  logic [V-1:0]  credit_eff;
  logic [V-1:0]  ovc_ok;
  logic [V-1:0]  err_vec;
  logic [VP-1:0] ovc_ok_pad;
  logic          any_free;
  logic          err_sticky_reg;

`ifdef OVC_CREDIT_REG_EN
  logic [V-1:0] credit_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) credit_reg <= '0;
    else       credit_reg <= credit_in;
  end

  assign credit_eff = credit_reg;
`else
  assign credit_eff = credit_in;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < V; gi++) begin : g_ovc
      logic dec;
      logic set;

      assign dec = flit_sent   && (flit_sent_ovc == VW'(gi));
      assign set = alloc_valid && (alloc_ovc     == VW'(gi));

      ovc_credit_counter #(
        .B  (B),
        .CW (CW)
      ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .dec       (dec),
        .inc       (credit_eff[gi]),
        .alloc_set (set),
        .alloc_clr (dec & flit_sent_tail),
        .err_event (err_vec[gi]),
        .free      (ovc_free[gi]),
        .full      (ovc_full[gi]),
        .ok        (ovc_ok[gi])
      );
    end
  endgenerate

  assign ovc_ok_pad = VP'(ovc_ok);
  assign any_free   = |ovc_free;

  // Unassigned IVCs need some free OVC to win allocation; assigned IVCs
  // need a credit on their own OVC.
  generate
    for (gi = 0; gi < R; gi++) begin : g_req
      logic [VW-1:0] ovc_idx;

      assign ovc_idx     = req_ovc[gi*VW +: VW];
      assign req_out[gi] = req_in[gi] &
                           (req_assigned[gi] ? ovc_ok_pad[ovc_idx] : any_free);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_sticky_reg <= 1'b0;
    else       err_sticky_reg <= err_sticky_reg | (|err_vec);
  end

  assign err_sticky = err_sticky_reg;

endmodule

// File: doc/ovc_credit_req_mask.md
OVC_CREDIT_REQ_MASK -- requests

Module: ovc_credit_req_mask

Interface
- REQ-001 SHALL have parameter V, default 4: number of OVCs at the output port.
- REQ-002 SHALL have parameter B, default 4: flit buffer depth per downstream VC.
- REQ-003 SHALL have parameter R, default 8: number of requesting IVCs (all input ports, all VCs).
- REQ-004 SHALL derive localparams VW = max(1, clog2(V)) and CW = clog2(B+1).
- REQ-005 SHALL have port clk, input, 1: clock.
- REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
- REQ-007 SHALL have port req_in, input, R: IVC not-empty request.
- REQ-008 SHALL have port req_assigned, input, R: IVC already holds an OVC of this port.
- REQ-009 SHALL have port req_ovc, input, R*VW: assigned OVC index per IVC, valid when req_assigned.
- REQ-010 SHALL have port req_out, input-masked output, R: filtered request.
- REQ-011 SHALL have port flit_sent, input, 1, and port flit_sent_ovc, input, VW: flit forwarded downstream.
- REQ-012 SHALL have port flit_sent_tail, input, 1: the forwarded flit is a tail.
- REQ-013 SHALL have port alloc_valid, input, 1, and port alloc_ovc, input, VW: OVC allocated to a packet.
- REQ-014 SHALL have port credit_in, input, V: one-hot-per-VC credit return (several bits may be set).
- REQ-015 SHALL have port ovc_free, output, V: OVC unallocated and credit == B.
- REQ-016 SHALL have port ovc_full, output, V: credit == 0.
- REQ-017 SHALL have port err_sticky, output, 1: a credit overflow or underflow was attempted.

Function
- REQ-018 SHALL keep a per-OVC credit counter, CW bits: -1 on flit_sent to that OVC, +1 on credit_in bit; both in the same cycle leave it unchanged.
- REQ-019 SHALL set the allocated flag on alloc_valid; SHALL clear it on flit_sent with flit_sent_tail; simultaneous set and clear to the same OVC leaves it set.
- REQ-020 SHALL drive req_out[i] = req_in & ~req_assigned & |ovc_free for an unassigned IVC (combinational, same cycle).
- REQ-021 SHALL drive req_out[i] = req_in & req_assigned & ok(ovc) for an assigned IVC, where ok = cnt >= 2, or cnt == 1 with no flit_sent to that OVC this cycle.
- REQ-022 SHALL, on a decrement at cnt == 0, hold cnt at 0 and set err_sticky.
- REQ-023 SHALL, on an increment at cnt == B, hold cnt at B and set err_sticky.
- REQ-024 SHALL clear err_sticky only by reset.
- REQ-025 SHALL derive ovc_free and ovc_full from registered state only, with no input-to-output path.

Reset
- REQ-026 SHALL, on reset, set every credit counter to B, clear every allocated flag and clear err_sticky.
- REQ-027 SHALL, as a consequence, drive ovc_free all-ones, ovc_full all-zeros and err_sticky 0 during and after reset; req_out follows REQ-020/021 from that state.
- REQ-028 SHALL let reset asserted mid-packet discard in-flight credits without raising err_sticky.

Configuration
- REQ-029 SHALL, with OVC_CREDIT_REG_EN defined, register credit_in for one cycle before counting, so a credit takes effect 2 cycles after arrival.
- REQ-030 SHALL, without OVC_CREDIT_REG_EN, apply credit_in in the cycle it arrives, so the counter is updated at the next edge.
- REQ-031 SHALL clear the credit register on reset.

Structure
- REQ-032 SHALL place the shared package constants in the codebase's define file: default V, B and the log2 function.
- REQ-033 SHALL place the per-OVC counter, its allocated flag and its error detection in one sub-module, ovc_credit_counter, instantiated V times.

Verification
- REQ-034 Reset with B=4 -> ovc_free=4'b1111, all counters 4, err_sticky=0.
- REQ-035 alloc OVC1, then 4 flit_sent to OVC1 without credits -> ovc_full[1]=1 after the 4th; assigned req to OVC1 masked once cnt<=1 while sending.
- REQ-036 cnt[2]=1 with flit_sent to OVC2 and an assigned request to OVC2 in the same cycle -> req_out=0; with no send -> req_out=1.
- REQ-037 Simultaneous flit_sent and credit_in on OVC0 at cnt=3 -> cnt stays 3, err_sticky=0.
- REQ-038 credit_in on OVC3 at cnt=B -> cnt=B, err_sticky=1 and held until reset.
- REQ-039 Tail sent on OVC1 plus 4 credits returned -> ovc_free[1]=1; an unassigned request passes; with OVC_CREDIT_REG_EN the pass is one cycle later.
